// File: rtl/instr_prefetch_buffer_pkg.sv
// Package: instr_prefetch_buffer_pkg
// Purpose: Shared constants, the queue entry type and a PC helper for the
//          instruction prefetch buffer.
//   NOP              - instruction presented when the queue is empty
//   DEFAULT_RESET_PC - fetch PC loaded on reset unless overridden
//   fetch_entry_t    - one queued instruction plus its pc+1 tag
package instr_prefetch_buffer_pkg;

    localparam logic [15:0] NOP              = 16'h0000;
    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc_plus_1;
    } fetch_entry_t;

    // 16-bit increment; FFFF wraps to 0000 by truncation.
    function automatic logic [15:0] pc_inc(input logic [15:0] pc);
        return pc + 16'd1;
    endfunction

endpackage

// File: rtl/instr_prefetch_buffer_if.sv
// Interface: instr_prefetch_buffer_if
// Purpose: Bundles the redirect, instruction-memory and consumer-side
//          signals of the prefetch buffer.
//   master - prefetch buffer side: drives imem_req/imem_addr, out_* and occupancy
//   slave  - environment side: drives redirect, imem_rdata and out_ready
interface instr_prefetch_buffer_if #(
    parameter int DEPTH = 4
);
    logic                     redirect_valid;
    logic [15:0]              redirect_addr;
    logic                     imem_req;
    logic [15:0]              imem_addr;
    logic [15:0]              imem_rdata;
    logic                     out_valid;
    logic [15:0]              out_instr;
    logic [15:0]              out_pc_plus_1;
    logic                     out_ready;
    logic [$clog2(DEPTH):0]   occupancy;

    modport master (
        input  redirect_valid, redirect_addr, imem_rdata, out_ready,
        output imem_req, imem_addr, out_valid, out_instr, out_pc_plus_1, occupancy
    );

    modport slave (
        output redirect_valid, redirect_addr, imem_rdata, out_ready,
        input  imem_req, imem_addr, out_valid, out_instr, out_pc_plus_1, occupancy
    );
endinterface

// File: rtl/instr_prefetch_buffer_fifo.sv
// Module: instr_prefetch_buffer_fifo
// Purpose: DEPTH-entry synchronous FIFO of fetch entries with push, pop and
//          clear, wrapping read/write pointers and an entry count.
// Ports:
//   clk      - clock
//   srst     - synchronous active-high reset (empties the FIFO)
//   i_push   - write i_wdata at the tail
//   i_pop    - drop the head entry
//   i_clear  - empty the FIFO; overrides push and pop in the same cycle
//   i_wdata  - entry to write
//   o_rdata  - head entry (meaningful only when o_count != 0)
//   o_count  - number of entries held, 0..DEPTH
module instr_prefetch_buffer_fifo
    import instr_prefetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_clear,
    input  fetch_entry_t             i_wdata,
    output fetch_entry_t             o_rdata,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_pop;
    logic w_push;

    assign w_pop  = i_pop && !i_clear && (r_count != '0);
    // A full FIFO accepts a push only if the head leaves in the same cycle.
    assign w_push = i_push && !i_clear && ((r_count != CW'(DEPTH)) || w_pop);

    // Storage carries no reset; validity is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (w_push && !srst) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (srst || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Module: instr_prefetch_buffer
// Purpose: Fetch-side front end. Owns the fetch PC, issues at most one request
//          per cycle to a 1-cycle-latency instruction memory and queues the
//          returned instructions tagged with pc+1, so that decode stalls do
//          not stall fetch and branch redirects flush cleanly.
// Ports:
//   clk       - clock
//   pc_reset  - synchronous active-high reset
//   bus       - master modport: redirect_valid/addr, imem_req/addr/rdata,
//               out_valid/instr/pc_plus_1, out_ready, occupancy
module instr_prefetch_buffer
    import instr_prefetch_buffer_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                        clk,
    input  logic                        pc_reset,
    instr_prefetch_buffer_if.master     bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [15:0]   r_fetch_pc;
    logic          r_inflight;
    logic [15:0]   r_ret_addr;

    logic [CW-1:0] w_count;
    logic [CW:0]   w_credits_used;
    logic          w_issue;
    logic          w_out_valid;
    logic          w_pop;
    fetch_entry_t  w_head;
    fetch_entry_t  w_push_entry;

    // Credits are taken from registered counts only: a pop this cycle does
    // not free a slot until next cycle, which keeps the issue path short.
    assign w_credits_used = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
    assign w_issue = !pc_reset && !bus.redirect_valid &&
                     (w_credits_used < (CW + 1)'(DEPTH));

    assign w_out_valid = (w_count != '0);
    assign w_pop       = w_out_valid && bus.out_ready;

    assign w_push_entry.instr     = bus.imem_rdata;
    assign w_push_entry.pc_plus_1 = pc_inc(r_ret_addr);

    // The only return that can be stale is the one on imem_rdata during a
    // redirect or reset cycle (no request is issued in those cycles); the
    // FIFO's clear/reset outranks that push, so it is discarded there.
    instr_prefetch_buffer_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .srst    (pc_reset),
        .i_push  (r_inflight),
        .i_pop   (w_pop),
        .i_clear (bus.redirect_valid),
        .i_wdata (w_push_entry),
        .o_rdata (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (pc_reset) begin
            r_fetch_pc <= RESET_PC;
            r_inflight <= 1'b0;
            r_ret_addr <= '0;
        end else begin
            r_inflight <= w_issue;
            if (bus.redirect_valid) begin
                r_fetch_pc <= bus.redirect_addr;
            end else if (w_issue) begin
                r_fetch_pc <= pc_inc(r_fetch_pc);
                r_ret_addr <= r_fetch_pc;
            end
        end
    end

    assign bus.imem_req      = w_issue;
    assign bus.imem_addr     = r_fetch_pc;
    assign bus.out_valid     = w_out_valid;
    assign bus.out_instr     = w_out_valid ? w_head.instr     : NOP;
    assign bus.out_pc_plus_1 = w_out_valid ? w_head.pc_plus_1 : 16'h0000;
    assign bus.occupancy     = w_count;

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Testbench: tb_instr_prefetch_buffer
// Purpose: Directed and randomized checks of instr_prefetch_buffer against a
//          queue-based reference model. A second instance with
//          RESET_PC=16'hFFFE covers PC wrap-around.
module tb_instr_prefetch_buffer;
    import instr_prefetch_buffer_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic pc_reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    instr_prefetch_buffer_if #(.DEPTH(DEPTH)) bus  ();
    instr_prefetch_buffer_if #(.DEPTH(DEPTH)) bus2 ();

    instr_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
        .clk      (clk),
        .pc_reset (pc_reset),
        .bus      (bus.master)
    );

    instr_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(16'hFFFE)) dut2 (
        .clk      (clk),
        .pc_reset (pc_reset),
        .bus      (bus2.master)
    );

    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return 16'h1000 + a;
    endfunction

    // Synchronous instruction memory: data for the address of cycle t
    // appears in cycle t+1.
    always @(posedge clk) begin
        bus.imem_rdata  <= mem_f(bus.imem_addr);
        bus2.imem_rdata <= mem_f(bus2.imem_addr);
    end

    // Reference model: architectural view of the buffer as a queue of
    // {instr, pc+1} plus one pending memory return.
    logic [31:0] m_q[$];
    logic [15:0] m_pc;
    bit          m_pend;
    logic [15:0] m_pend_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare every output with the model,
    // then advance the model at the edge.
    task automatic cyc(input bit rst, input bit redir, input logic [15:0] raddr, input bit ready);
        bit          e_req;
        bit          e_valid;
        logic [31:0] head;
        pc_reset           = rst;
        bus.redirect_valid = redir;
        bus.redirect_addr  = raddr;
        bus.out_ready      = ready;
        #1;
        e_req   = !rst && !redir && ((m_q.size() + int'(m_pend)) < DEPTH);
        e_valid = (m_q.size() > 0);
        head    = e_valid ? m_q[0] : {NOP, 16'h0000};
        chk("imem_req",      {31'd0, bus.imem_req},  {31'd0, e_req});
        chk("imem_addr",     {16'd0, bus.imem_addr}, {16'd0, m_pc});
        chk("out_valid",     {31'd0, bus.out_valid}, {31'd0, e_valid});
        chk("out_instr",     {16'd0, bus.out_instr}, {16'd0, head[31:16]});
        chk("out_pc_plus_1", {16'd0, bus.out_pc_plus_1}, {16'd0, head[15:0]});
        chk("occupancy",     32'(bus.occupancy),     32'(m_q.size()));
        @(posedge clk);
        if (rst) begin
            m_pc = 16'h0000;
            m_q.delete();
            m_pend = 0;
        end else if (redir) begin
            m_pc = raddr;
            m_q.delete();
            m_pend = 0;
        end else begin
            if (e_valid && ready) void'(m_q.pop_front());
            if (m_pend) m_q.push_back({mem_f(m_pend_addr), m_pend_addr + 16'd1});
            m_pend = e_req;
            if (e_req) begin
                m_pend_addr = m_pc;
                m_pc = m_pc + 16'd1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        pc_reset            = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_addr   = 16'h0000;
        bus.out_ready       = 1'b1;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_addr  = 16'h0000;
        bus2.out_ready      = 1'b1;
        m_pc = 16'h0000; m_pend = 0; m_pend_addr = 16'h0000;
        @(negedge clk);

        // Reset, then stream with out_ready=1.
        cyc(1, 0, 0, 1); cyc(1, 0, 0, 1);
        chk("rst_occupancy", 32'(bus.occupancy), 32'd0);
        chk("rst_out_instr", {16'd0, bus.out_instr}, {16'd0, NOP});
        chk("rst_pc1",       {16'd0, bus.out_pc_plus_1}, 32'd0);
        chk("dut2_addr0",    {16'd0, bus2.imem_addr}, 32'h0000_FFFE);
        cyc(0, 0, 0, 1);
        chk("dut2_addr1",    {16'd0, bus2.imem_addr}, 32'h0000_FFFF);
        cyc(0, 0, 0, 1);
        chk("dut2_addr2",    {16'd0, bus2.imem_addr}, 32'h0000_0000);
        chk("head0_instr",   {16'd0, bus.out_instr},  32'h0000_1000);
        chk("head0_pc1",     {16'd0, bus.out_pc_plus_1}, 32'h0000_0001);
        chk("dut2_head0",    {bus2.out_instr, bus2.out_pc_plus_1}, 32'h0FFE_FFFF);
        cyc(0, 0, 0, 1);
        chk("head1",         {bus.out_instr, bus.out_pc_plus_1}, 32'h1001_0002);
        chk("dut2_head1",    {bus2.out_instr, bus2.out_pc_plus_1}, 32'h0FFF_0000);
        cyc(0, 0, 0, 1);
        chk("head2",         {bus.out_instr, bus.out_pc_plus_1}, 32'h1002_0003);
        chk("dut2_head2",    {bus2.out_instr, bus2.out_pc_plus_1}, 32'h1000_0001);
        $display("step: stream after reset done");

        // Stall for 10 cycles: queue saturates, fetch stops at PC 4.
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0);
        chk("full_occupancy", 32'(bus.occupancy), 32'd4);
        chk("full_req",       {31'd0, bus.imem_req}, 32'd0);
        chk("full_pc",        {16'd0, bus.imem_addr}, 32'h0000_0004);
        chk("full_head",      {bus.out_instr, bus.out_pc_plus_1}, 32'h1000_0001);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1);
        $display("step: saturate and drain done");

        // Redirect with 3 queued and 1 in flight.
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
        chk("pre_redir_occ", 32'(bus.occupancy), 32'd3);
        cyc(0, 1, 16'h0040, 0);
        chk("redir_occ",     32'(bus.occupancy), 32'd0);
        chk("redir_pc",      {16'd0, bus.imem_addr}, 32'h0000_0040);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("redir_head",    {bus.out_instr, bus.out_pc_plus_1}, 32'h1040_0041);
        $display("step: redirect with in-flight return done");

        // Redirect and pop in the same cycle with a full queue.
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0);
        chk("full2_occ",     32'(bus.occupancy), 32'd4);
        cyc(0, 1, 16'h0080, 1);
        chk("redir_pop_occ", 32'(bus.occupancy), 32'd0);
        chk("redir_pop_vld", {31'd0, bus.out_valid}, 32'd0);
        $display("step: redirect with pop on full queue done");

        // Back-to-back redirects: only the last target is fetched.
        cyc(0, 1, 16'h0100, 1);
        cyc(0, 1, 16'h0200, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("b2b_head",      {bus.out_instr, bus.out_pc_plus_1}, 32'h1200_0201);
        $display("step: back-to-back redirects done");

        // Reset in the middle of a stream.
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 1);
        chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_instr", {16'd0, bus.out_instr}, {16'd0, NOP});
        chk("mid_rst_pc",    {16'd0, bus.imem_addr}, 32'h0000_0000);
        chk("mid_rst_pc2",   {16'd0, bus2.imem_addr}, 32'h0000_FFFE);
        $display("step: mid-stream reset done");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0,
                16'($urandom), $urandom_range(0, 9) < 7);
        end
        $display("step: randomized traffic done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
